// File: rtl/sim_uart_monitor.sv
// sim_uart_monitor: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// It also keeps error and overflow flags, a received-byte count and a sticky end-of-transmission flag.
module sim_uart_monitor #(
  parameter int          CLK_FREQ   = 100000000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  EOT_BYTE   = 8'h04
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_uart_rx,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        in_ready,
  output logic        out_framing_err,
  output logic        out_overflow,
  output logic [15:0] out_rx_count,
  output logic        out_eot,
  output logic        out_busy
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
  state_t        r_state;
  logic          r_s1, r_s2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_fe;
  logic          r_ovf;
  logic          r_eot;
  logic [15:0]   r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic          w_empty, w_full, w_pop, w_good, w_push;
  assign w_empty = r_wp == r_rp;
  assign w_full  = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign w_pop   = !w_empty && in_ready;
  assign w_good  = r_state == STOP && r_cnt == CW'(CPB - 1) && r_s2;
  assign w_push  = w_good && (!w_full || w_pop);
  assign out_valid       = !w_empty;
  assign out_data        = w_empty ? 8'h00 : r_mem[r_rp[AW-1:0]];
  assign out_framing_err = r_fe;
  assign out_overflow    = r_ovf;
  assign out_rx_count    = r_count;
  assign out_eot         = r_eot;
  assign out_busy        = r_state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= in_uart_rx;
      r_s2 <= r_s1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_fe    <= 1'b0;
    end else begin
      r_fe <= 1'b0;
      case (r_state)
        IDLE: if (!r_s2) begin
          r_state <= START;
          r_cnt   <= '0;
        end
        START: if (r_cnt == CW'(HALF - 1)) begin
          r_cnt   <= '0;
          r_bit   <= '0;
          r_state <= r_s2 ? IDLE : DATA;
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (r_cnt == CW'(CPB - 1)) begin
          r_cnt          <= '0;
          r_shift[r_bit] <= r_s2;
          r_bit          <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
        STOP: if (r_cnt == CW'(CPB - 1)) begin
          r_cnt   <= '0;
          r_fe    <= !r_s2;
          r_state <= r_s2 ? IDLE : WAIT_HIGH;
        end else r_cnt <= r_cnt + 1'b1;
        WAIT_HIGH: if (r_s2) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // a good byte is pushed on the same edge that samples its stop bit
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= r_shift;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_ovf   <= 1'b0;
      r_eot   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_good && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_good && r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      if (w_good && r_shift == EOT_BYTE) r_eot <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sim_uart_monitor.sv
// tb_sim_uart_monitor: table-driven and randomized frames checked against a queue-based model.
// The bench runs with CPB=16 and HALF=8, and it also has hand-written overflow, EOT, glitch and reset sequences.
module tb_sim_uart_monitor;
  localparam int CPB = 16;
  localparam int HALF = 8;
  localparam int DEPTH = 16;
  localparam int STOP_LAT = 155;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid, out_framing_err, out_overflow, out_eot, out_busy;
  logic [15:0] out_rx_count;
  sim_uart_monitor #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH), .EOT_BYTE(8'h04)) dut (
    .clock(clk), .reset(reset), .in_uart_rx(rx), .out_data(out_data), .out_valid(out_valid),
    .in_ready(ready), .out_framing_err(out_framing_err), .out_overflow(out_overflow),
    .out_rx_count(out_rx_count), .out_eot(out_eot), .out_busy(out_busy));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] got_q[$];
  int fe_cnt = 0, busy_cyc = 0, valid_cyc = 0, valid_rise = -1, eot_rise = -1;
  logic pv = 1'b0, pe = 1'b0;
  always @(negedge clk) if (!reset) begin
    if (out_valid && ready) got_q.push_back(out_data);
    if (out_framing_err) fe_cnt <= fe_cnt + 1;
    if (out_busy) busy_cyc <= busy_cyc + 1;
    if (out_valid) valid_cyc <= valid_cyc + 1;
    if (out_valid && !pv) valid_rise <= cyc;
    if (out_eot && !pe) eot_rise <= cyc;
    pv <= out_valid;
    pe <= out_eot;
  end
  logic [7:0] m_fifo[$];
  logic [7:0] exp_del[$];
  int m_count = 0, m_fe = 0, del_chk = 0;
  bit m_ovf = 1'b0, m_eot = 1'b0;
  typedef struct { logic [7:0] data; bit stop_ok; bit rdy; int exp_fe; int exp_inc; } vec_t;
  vec_t vecs[20];
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction
  function automatic void drain_model();
    while (m_fifo.size() != 0) exp_del.push_back(m_fifo.pop_front());
  endfunction
  function automatic void model_frame(logic [7:0] b, bit ok);
    if (!ok) m_fe++;
    else begin
      m_count = (m_count == 65535) ? 65535 : m_count + 1;
      if (b == 8'h04) m_eot = 1'b1;
      if (m_fifo.size() == DEPTH) m_ovf = 1'b1;
      else m_fifo.push_back(b);
      if (ready) drain_model();
    end
  endfunction
  function automatic void model_reset();
    m_fifo.delete();
    m_count = 0;
    m_ovf = 1'b0;
    m_eot = 1'b0;
  endfunction
  function automatic void check_state();
    chk("rx_count", out_rx_count, m_count);
    chk("overflow", out_overflow, m_ovf);
    chk("eot", out_eot, m_eot);
    chk("framing_pulses", fe_cnt, m_fe);
    chk("valid", out_valid, m_fifo.size() != 0);
    if (m_fifo.size() != 0) chk("head", out_data, m_fifo[0]);
    chk("delivered", got_q.size(), exp_del.size());
    for (int i = del_chk; i < got_q.size() && i < exp_del.size(); i++) chk("order", got_q[i], exp_del[i]);
    del_chk = (got_q.size() < exp_del.size()) ? got_q.size() : exp_del.size();
  endfunction
  function automatic void check_zero();
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_fe", out_framing_err, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_count", out_rx_count, 0);
    chk("rst_eot", out_eot, 0);
    chk("rst_busy", out_busy, 0);
  endfunction
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int s);
    tick();
    rx = 1'b0;
    s = cyc;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_ok;
    repeat (CPB) tick();
    if (!stop_ok) repeat (24) tick();
    rx = 1'b1;
    repeat (4) tick();
    model_frame(b, stop_ok);
  endtask
  initial begin
    int s, fe0, cnt0, v0, b0;
    logic [7:0] pb;
    vecs[0] = '{8'h55, 1'b1, 1'b1, 0, 1};
    vecs[1] = '{8'hA5, 1'b0, 1'b1, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 0, 1};
    for (int i = 3; i < 20; i++) begin
      vecs[i].data = 8'($urandom);
      vecs[i].stop_ok = $urandom_range(0, 4) != 0;
      vecs[i].rdy = 1'b1;
      vecs[i].exp_fe = vecs[i].stop_ok ? 0 : 1;
      vecs[i].exp_inc = vecs[i].stop_ok ? 1 : 0;
    end
    repeat (3) tick();
    check_zero();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      ready = vecs[i].rdy;
      fe0 = fe_cnt;
      cnt0 = out_rx_count;
      v0 = valid_cyc;
      send_frame(vecs[i].data, vecs[i].stop_ok, s);
      chk("vec_fe", fe_cnt - fe0, vecs[i].exp_fe);
      chk("vec_inc", out_rx_count - cnt0, vecs[i].exp_inc);
      chk("vec_valid_cycles", valid_cyc - v0, vecs[i].exp_inc);
      if (vecs[i].stop_ok) chk("valid_latency", valid_rise - s, STOP_LAT);
      chk("busy_done", out_busy, 0);
      check_state();
    end
    b0 = busy_cyc;
    tick();
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (20) tick();
    chk("glitch_busy", busy_cyc - b0, HALF);
    chk("glitch_busy_end", out_busy, 0);
    check_state();
    ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, s);
    check_state();
    chk("ovf_set", out_overflow, 1);
    tick();
    ready = 1'b1;
    drain_model();
    repeat (30) tick();
    check_state();
    chk("ovf_drained", out_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check_zero();
    send_frame(8'h48, 1'b1, s);
    send_frame(8'h69, 1'b1, s);
    chk("eot_early", out_eot, 0);
    send_frame(8'h04, 1'b1, s);
    chk("eot_latency", eot_rise - s, STOP_LAT);
    repeat (50) tick();
    check_state();
    ready = 1'b0;
    send_frame(8'h11, 1'b1, s);
    chk("pre_reset_valid", out_valid, 1);
    pb = 8'hC3;
    tick();
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = pb[i];
      repeat (CPB) tick();
    end
    repeat (HALF) tick();
    chk("mid_busy", out_busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check_zero();
    repeat (20) tick();
    ready = 1'b1;
    send_frame(8'h7E, 1'b1, s);
    chk("after_reset_count", out_rx_count, 1);
    check_state();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sim_uart_monitor.md
Name: sim_uart_monitor

Overview:
- Simulation-side UART receiver that consumes the serial line driven by the design's out_uart_tx in the Icarus top, and sits directly downstream of M_main.
- Decodes 8N1 frames into bytes and buffers them in a small FIFO with a valid/ready output, so the top can print them.
- Raises a sticky end-of-transmission flag when a designated byte arrives, which lets the top end the simulation.
- Synthesizable RTL; contains no simulation-only constructs.

Parameters:
- CLK_FREQ, 100000000: clock frequency in Hz.
- BAUD, 115200: line rate in bit/s. CPB = CLK_FREQ/BAUD, integer division, truncated (868 at defaults). HALF = CPB/2 (434).
- FIFO_DEPTH, 16: byte FIFO entries; must be a power of two, minimum 2.
- EOT_BYTE, 8'h04: byte value that sets out_eot.

Ports:
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- in_uart_rx, in, 1: serial line from the design. Idle level is high.
- out_data, out, 8: FIFO head byte (first-word fall-through). Valid only while out_valid=1.
- out_valid, out, 1: FIFO not empty.
- in_ready, in, 1: consumer accepts the head byte. A pop occurs when out_valid and in_ready are both 1.
- out_framing_err, out, 1: one-cycle pulse when a stop bit is sampled low.
- out_overflow, out, 1: sticky; set when a good byte is dropped because the FIFO is full.
- out_rx_count, out, 16: count of correctly framed bytes. Saturates at 16'hFFFF.
- out_eot, out, 1: sticky; set when a good byte equal to EOT_BYTE is received.
- out_busy, out, 1: receiver state is not IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - Synchronizer flops reset to 1.
  - State goes to IDLE; bit and cycle counters clear to 0.
  - FIFO empties.
  - All outputs reset to 0: out_data, out_valid, out_framing_err, out_overflow, out_rx_count, out_eot, out_busy.
  - Reset mid-frame abandons the partial byte; the next start edge begins a fresh frame.
- Input synchronizer: in_uart_rx passes through a 2-flop synchronizer, giving 2 cycles of latency. The FSM sees only the synchronized line (rxs).
- FSM states and transitions:
  - IDLE: when rxs=0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt=HALF-1, sample rxs:
    - rxs=0: go to DATA with cnt=0, bit=0.
    - rxs=1 (glitch): go to IDLE; nothing is reported.
  - DATA: at cnt=CPB-1, sample rxs into shift[bit], LSB first, then set cnt=0 and bit=bit+1. After bit 7 is sampled, go to STOP.
  - STOP: at cnt=CPB-1, sample rxs:
    - rxs=1: the byte is good; go to IDLE.
    - rxs=0: pulse out_framing_err for 1 cycle, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a stuck-low line from producing repeated frames.
- Good-byte actions (taken in the cycle after the stop sample):
  - Push to the FIFO.
  - Increment out_rx_count (saturating).
  - If byte == EOT_BYTE, set out_eot. The EOT byte is still pushed.
- Latency: out_valid rises on the cycle after the good stop-bit sample when the FIFO was empty. out_data is valid in that same cycle.
- FIFO rules:
  - Push while full with no pop in the same cycle: byte dropped, out_overflow set, out_rx_count still increments.
  - Push while full with a simultaneous pop: accepted.
  - Push and pop while empty: the byte is pushed; it is not bypassed to the output.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
  - Full when the low bits are equal and the MSBs differ; empty when the pointers are equal.
  - Order is strictly preserved.
- Sticky flags (out_overflow, out_eot) clear only on reset.
- out_busy is 1 in START, DATA, STOP and WAIT_HIGH.

Test Plan:
- All scenarios use CLK_FREQ=16, BAUD=1 (CPB=16, HALF=8).
- Good byte: in_ready=1, send 0x55 as an 8N1 frame, each bit 16 cycles -> out_valid high exactly 1 cycle with out_data=0x55; out_rx_count=1; out_framing_err never asserted; out_busy returns to 0.
- Glitch: drive in_uart_rx low for 3 cycles, then high -> out_busy pulses, then returns to 0 by cnt=HALF-1; no byte; out_rx_count=0.
- Framing error: send 0xA5 with stop bit low, hold the line low 40 cycles, then high -> one out_framing_err pulse; no push; out_rx_count unchanged. A following 0x3C frame is received correctly.
- Overflow: in_ready=0, send bytes 0x00..0x10 (17 frames) -> out_overflow=1 after the 17th; out_rx_count=17. Raising in_ready then pops 0x00..0x0F in order, after which out_valid=0.
- EOT: send 0x48, 0x69, 0x04 -> data 0x48, 0x69, 0x04 delivered in order; out_eot=0 until the cycle after the third stop sample, then 1 and held.
- Reset mid-frame: assert reset for 1 cycle during DATA bit 4 -> all outputs 0 and FIFO empty. A subsequent 0x7E frame is received correctly with out_rx_count=1.
